// File: rtl/golden_data_memory.sv
// Data-memory responder for the single-cycle core: word-addressed RAM with
// combinational loads, clocked stores and four memory-mapped control registers.
module golden_data_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic                  timer_expired
);

  localparam int WORDS     = 1 << ADDR_WIDTH;
  localparam int RAM_WORDS = WORDS - 4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_CYCLE  = ADDR_WIDTH'(WORDS - 4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TIMER  = ADDR_WIDTH'(WORDS - 3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_GPIO   = ADDR_WIDTH'(WORDS - 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(WORDS - 1);

  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];

  logic [DATA_WIDTH-1:0] cycle;
  logic [DATA_WIDTH-1:0] timer;
  logic [DATA_WIDTH-1:0] gpio;
  logic [1:0]            status;

  logic                  is_ram;
  logic                  wr_cycle;
  logic                  wr_timer;
  logic                  wr_gpio;
  logic                  wr_status;
  logic                  timer_fire;
  logic [1:0]            status_set;
  logic [1:0]            status_clr;
  logic [DATA_WIDTH-1:0] rdata;

  assign is_ram    = (address < ADDR_CYCLE);
  assign wr_cycle  = write && (address == ADDR_CYCLE);
  assign wr_timer  = write && (address == ADDR_TIMER);
  assign wr_gpio   = write && (address == ADDR_GPIO);
  assign wr_status = write && (address == ADDR_STATUS);

  // A store to TIMER preempts the decrement, so it can never fire that edge.
  assign timer_fire = !wr_timer && (timer == DATA_WIDTH'(1));
  assign status_set = {wr_cycle, timer_fire};
  assign status_clr = wr_status ? data_out[1:0] : 2'b00;

  // Load path: combinational, returns pre-edge contents.
  always_comb begin
    rdata = '0;
    if (read) begin
      if (is_ram) begin
        rdata = ram[address];
      end else begin
        case (address)
          ADDR_CYCLE:  rdata = cycle;
          ADDR_TIMER:  rdata = timer;
          ADDR_GPIO:   rdata = gpio;
          ADDR_STATUS: rdata = {{(DATA_WIDTH-2){1'b0}}, status};
          default:     rdata = '0;
        endcase
      end
    end
  end

  assign data_in       = rdata;
  assign gpio_out      = gpio;
  assign timer_expired = status[0];

  // RAM is never cleared; stores arriving while reset is held are dropped.
  always_ff @(posedge clock) begin
    if (write && is_ram && reset) begin
      ram[address] <= data_out;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle  <= '0;
      timer  <= '0;
      gpio   <= '0;
      status <= 2'b00;
    end else begin
      cycle <= cycle + DATA_WIDTH'(1);
      if (wr_timer) begin
        timer <= data_out;
      end else if (timer != '0) begin
        timer <= timer - DATA_WIDTH'(1);
      end
      if (wr_gpio) begin
        gpio <= data_out;
      end
      // Set has priority over a same-edge write-1-to-clear.
      status <= status_set | (status & ~status_clr);
    end
  end

endmodule

// File: tb/tb_golden_data_memory.sv
// Self-checking bench for golden_data_memory: directed scenarios plus a
// randomized mix, compared against a behavioural model of the memory map.
module tb_golden_data_memory;

  localparam logic [9:0] A_CYCLE  = 10'h3FC;
  localparam logic [9:0] A_TIMER  = 10'h3FD;
  localparam logic [9:0] A_GPIO   = 10'h3FE;
  localparam logic [9:0] A_STATUS = 10'h3FF;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [9:0]  address;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic [31:0] gpio_out;
  logic        timer_expired;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] mram [int];
  logic [31:0] mcycle;
  logic [31:0] mtimer;
  logic [31:0] mgpio;
  logic [1:0]  mstat;

  golden_data_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .read(read),
    .write(write),
    .address(address),
    .data_out(data_out),
    .data_in(data_in),
    .gpio_out(gpio_out),
    .timer_expired(timer_expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_read(input logic [9:0] a);
    if (a < A_CYCLE) return mram.exists(int'(a)) ? mram[int'(a)] : 32'h0;
    if (a == A_CYCLE) return mcycle;
    if (a == A_TIMER) return mtimer;
    if (a == A_GPIO) return mgpio;
    return {30'b0, mstat};
  endfunction

  task automatic model_reset();
    mcycle = 0;
    mtimer = 0;
    mgpio  = 0;
    mstat  = 2'b00;
  endtask

  task automatic model_edge(input logic w, input logic [9:0] a, input logic [31:0] d);
    logic       expire;
    logic       illegal;
    logic [1:0] clr;
    expire  = 1'b0;
    illegal = 1'b0;
    clr     = 2'b00;
    mcycle  = mcycle + 1;
    if (w && a == A_TIMER) begin
      mtimer = d;
    end else if (mtimer > 0) begin
      mtimer = mtimer - 1;
      expire = (mtimer == 0);
    end
    if (w) begin
      if (a < A_CYCLE) mram[int'(a)] = d;
      else if (a == A_CYCLE) illegal = 1'b1;
      else if (a == A_GPIO) mgpio = d;
      else if (a == A_STATUS) clr = d[1:0];
    end
    mstat = mstat & ~clr;
    if (expire) mstat[0] = 1'b1;
    if (illegal) mstat[1] = 1'b1;
  endtask

  // One bus cycle: drive, sample the load mid-cycle, then cross the edge.
  task automatic cyc(input logic r, input logic w, input logic [9:0] a,
                     input logic [31:0] d, output logic [31:0] obs,
                     output logic [31:0] expv);
    read = r; write = w; address = a; data_out = d;
    #2;
    obs  = data_in;
    expv = r ? model_read(a) : 32'h0;
    @(posedge clock);
    model_edge(w, a, d);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] a;
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_out = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (gpio_out !== 32'h0 || timer_expired !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs gpio=%h te=%b required gpio=0 te=0", gpio_out, timer_expired);
    end
    read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = A_CYCLE + 10'(i);
      address = a;
      #1;
      checks++;
      if (data_in !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h required=0", i, data_in);
      end
    end
    read = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_cycle_illegal();
    logic [31:0] obs, expv;
    cyc(1, 0, A_CYCLE, 0, obs, expv);
    checks++;
    if (obs !== 32'd0 || obs !== expv) begin
      failures++;
      $display("FAIL cycle_first got=%0d required=0", obs);
    end
    repeat (4) cyc(0, 0, 10'h0, 0, obs, expv);
    cyc(1, 0, A_CYCLE, 0, obs, expv);
    checks++;
    if (obs !== 32'd5 || obs !== expv) begin
      failures++;
      $display("FAIL cycle_fifth got=%0d required=5", obs);
    end
    cyc(0, 1, A_CYCLE, 32'hFF, obs, expv);
    cyc(1, 0, A_STATUS, 0, obs, expv);
    checks++;
    if (obs !== 32'h2 || obs !== expv) begin
      failures++;
      $display("FAIL illegal_status got=%h required=2", obs);
    end
    cyc(1, 0, A_CYCLE, 0, obs, expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL cycle_after_illegal got=%0d required=%0d", obs, expv);
    end
    cyc(0, 1, A_STATUS, 32'h3, obs, expv);
    cyc(1, 0, A_STATUS, 0, obs, expv);
    checks++;
    if (obs !== 32'h0) begin
      failures++;
      $display("FAIL status_clear got=%h required=0", obs);
    end
  endtask

  task automatic test_ram();
    logic [31:0] obs, expv;
    cyc(0, 1, 10'h005, 32'hDEADBEEF, obs, expv);
    cyc(1, 0, 10'h005, 0, obs, expv);
    checks++;
    if (obs !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL ram_readback got=%h required=deadbeef", obs);
    end
    cyc(0, 0, 10'h005, 0, obs, expv);
    checks++;
    if (obs !== 32'h0) begin
      failures++;
      $display("FAIL ram_read_idle got=%h required=0", obs);
    end
    for (int i = 0; i < 32; i++) cyc(0, 1, 10'(i), $urandom, obs, expv);
    cyc(0, 1, 10'h3FB, 32'h0BADF00D, obs, expv);
    for (int i = 0; i < 16; i++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 31));
      cyc(1, 0, a, 0, obs, expv);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL ram_random addr=%h got=%h required=%h", a, obs, expv);
      end
    end
    cyc(1, 0, 10'h3FB, 0, obs, expv);
    checks++;
    if (obs !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL ram_top_word got=%h required=0badf00d", obs);
    end
  endtask

  task automatic test_same_cycle_rw();
    logic [31:0] obs, expv;
    cyc(0, 1, 10'h010, 32'h11, obs, expv);
    cyc(1, 1, 10'h010, 32'h22, obs, expv);
    checks++;
    if (obs !== 32'h11) begin
      failures++;
      $display("FAIL rw_old got=%h required=11", obs);
    end
    cyc(1, 0, 10'h010, 0, obs, expv);
    checks++;
    if (obs !== 32'h22) begin
      failures++;
      $display("FAIL rw_new got=%h required=22", obs);
    end
  endtask

  task automatic test_timer();
    logic [31:0] obs, expv;
    cyc(0, 1, A_TIMER, 32'd3, obs, expv);
    for (int k = 3; k >= 0; k--) begin
      cyc(1, 0, A_TIMER, 0, obs, expv);
      checks++;
      if (obs !== 32'(k) || obs !== expv) begin
        failures++;
        $display("FAIL timer_count got=%0d required=%0d", obs, k);
      end
    end
    checks++;
    if (timer_expired !== 1'b1) begin
      failures++;
      $display("FAIL timer_expired got=%b required=1", timer_expired);
    end
    cyc(0, 1, A_STATUS, 32'h1, obs, expv);
    checks++;
    if (timer_expired !== 1'b0) begin
      failures++;
      $display("FAIL timer_clear got=%b required=0", timer_expired);
    end
    cyc(0, 1, A_TIMER, 32'd2, obs, expv);
    cyc(0, 0, 10'h0, 0, obs, expv);
    cyc(0, 1, A_TIMER, 32'd0, obs, expv);
    repeat (2) cyc(0, 0, 10'h0, 0, obs, expv);
    checks++;
    if (timer_expired !== 1'b0) begin
      failures++;
      $display("FAIL timer_stop got=%b required=0", timer_expired);
    end
    cyc(0, 1, A_TIMER, 32'd1, obs, expv);
    checks++;
    if (timer_expired !== 1'b0) begin
      failures++;
      $display("FAIL timer_one_early got=%b required=0", timer_expired);
    end
    cyc(0, 0, 10'h0, 0, obs, expv);
    checks++;
    if (timer_expired !== 1'b1) begin
      failures++;
      $display("FAIL timer_one_fire got=%b required=1", timer_expired);
    end
    cyc(0, 1, A_STATUS, 32'h1, obs, expv);
  endtask

  task automatic test_collision();
    logic [31:0] obs, expv;
    cyc(0, 1, A_TIMER, 32'd2, obs, expv);
    cyc(0, 0, 10'h0, 0, obs, expv);
    cyc(0, 1, A_STATUS, 32'h1, obs, expv);
    checks++;
    if (timer_expired !== 1'b1 || mstat[0] !== 1'b1) begin
      failures++;
      $display("FAIL collision got=%b required=1", timer_expired);
    end
    cyc(0, 1, A_STATUS, 32'h1, obs, expv);
  endtask

  task automatic test_random_mix();
    logic [31:0] obs, expv;
    logic [9:0]  a;
    logic [31:0] d;
    logic        r, w;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31))
                                      : 10'($urandom_range(32'h3FC, 32'h3FF));
      r = 1'($urandom);
      w = ($urandom_range(0, 3) == 0);
      d = (a == A_TIMER) ? 32'($urandom_range(0, 5)) : $urandom;
      cyc(r, w, a, d, obs, expv);
      checks++;
      if (obs !== expv || gpio_out !== mgpio || timer_expired !== mstat[0]) begin
        failures++;
        $display("FAIL random addr=%h got=%h/%h/%b required=%h/%h/%b",
                 a, obs, gpio_out, timer_expired, expv, mgpio, mstat[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs, expv, old7;
    cyc(0, 1, 10'h007, 32'h12345678, obs, expv);
    old7 = 32'h12345678;
    cyc(0, 1, A_GPIO, 32'hA5, obs, expv);
    cyc(0, 1, A_TIMER, 32'd100, obs, expv);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gpio_out !== 32'h0 || timer_expired !== 1'b0) begin
      failures++;
      $display("FAIL midreset_out gpio=%h te=%b required gpio=0 te=0", gpio_out, timer_expired);
    end
    read = 1'b1; address = A_TIMER;
    #1;
    checks++;
    if (data_in !== 32'h0) begin
      failures++;
      $display("FAIL midreset_timer got=%0d required=0", data_in);
    end
    address = A_STATUS;
    #1;
    checks++;
    if (data_in !== 32'h0) begin
      failures++;
      $display("FAIL midreset_status got=%h required=0", data_in);
    end
    read = 1'b0; write = 1'b1; address = 10'h007; data_out = 32'hFFFF0000;
    @(posedge clock);
    #1;
    write = 1'b0;
    reset = 1'b1;
    cyc(1, 0, A_CYCLE, 0, obs, expv);
    checks++;
    if (obs !== 32'd0) begin
      failures++;
      $display("FAIL midreset_cycle got=%0d required=0", obs);
    end
    cyc(1, 0, 10'h007, 0, obs, expv);
    checks++;
    if (obs !== old7) begin
      failures++;
      $display("FAIL midreset_dropped_write got=%h required=%h", obs, old7);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_cycle_illegal();
    test_ram();
    test_same_cycle_rw();
    test_timer();
    test_collision();
    test_random_mix();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/golden_data_memory.md
# golden_data_memory

Data-memory responder for the single-cycle core's load/store port. It serves combinational reads and clocked writes from a word-addressed RAM. The top four words of the address space are memory-mapped control registers: a free-running cycle counter, a countdown timer, a GPIO output register and a sticky status register. It connects to the core's `read`/`write`/`address`/`data_out`/`data_in` port by name, with signal directions mirrored.

## Interface
- `ADDR_WIDTH`, default 10: word-address width; total space is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: word width.
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `read`  in  1  load request from the core (active 1).
- `write`  in  1  store request from the core (active 1).
- `address`  in  ADDR_WIDTH  word address.
- `data_out`  in  DATA_WIDTH  store data from the core. The name is from the core's view.
- `data_in`  out  DATA_WIDTH  load data to the core. The name is from the core's view.
- `gpio_out`  out  DATA_WIDTH  current GPIO register value.
- `timer_expired`  out  1  mirror of STATUS[0].

## Operation
- Memory map, with M = 2^ADDR_WIDTH:
  - 0 .. M-5: RAM, read/write.
  - M-4: CYCLE, read-only.
  - M-3: TIMER, read/write.
  - M-2: GPIO, read/write.
  - M-1: STATUS, read / write-1-to-clear.
- Read path is purely combinational.
  - `read`=1: `data_in` = selected word.
  - `read`=0: `data_in` = 0.
  - Unused STATUS bits read as 0.
- Write path: on a rising edge with `write`=1, the addressed RAM word or register is updated.
- `read` and `write` both 1: the write is performed, and `data_in` returns the pre-write contents of the address.
- RAM is not reset; its contents are undefined until written. All registers reset to 0.
- CYCLE:
  - Increments by 1 every cycle out of reset.
  - Wraps from 2^DATA_WIDTH-1 to 0.
  - A write to CYCLE is ignored and sets STATUS[1] (illegal-write flag).
- TIMER:
  - While nonzero, decrements by 1 per cycle.
  - On the edge where it goes from 1 to 0, STATUS[0] is set.
  - A write loads `data_out`. The write overrides that cycle's decrement.
  - Writing 0 stops the timer without setting STATUS[0].
  - Writing 1 sets STATUS[0] one cycle later.
  - A zero timer stays at 0; there is no reload.
- GPIO: holds the last written value and drives `gpio_out` directly.
- STATUS:
  - Bit0 = timer expired; bit1 = illegal write. Both are sticky.
  - Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - Set and clear on the same edge: set wins.
- `timer_expired` = STATUS[0], registered with no extra logic.

## Timing
- Load latency is 0 cycles: `data_in` is valid in the same cycle as `read`/`address`. This matches the core's single-cycle execute.
- Store latency is 1 edge: a store is visible to a load in the following cycle.
- Reading TIMER or CYCLE returns the current register value, i.e. before this edge's update.
- Reset assertion (asynchronous, mid-operation): CYCLE, TIMER, GPIO and STATUS are cleared immediately. `gpio_out`=0 and `timer_expired`=0. A pending write is dropped.
- Reset deassertion: CYCLE reads 0 in the first active cycle and 1 in the next.
- No handshake or back-pressure exists; every request completes in one cycle.

## Test plan
- RAM write then read:
  - Stimulus: write 0xDEADBEEF to 0x005, then read 0x005 in the next cycle.
  - Required: `data_in`=0xDEADBEEF. With `read`=0, `data_in`=0.
- Same-cycle read and write:
  - Stimulus: 0x010 holds 0x11; assert `read`=`write`=1 at 0x010 with `data_out`=0x22.
  - Required: `data_in`=0x11 that cycle and 0x22 the next.
- Timer:
  - Stimulus: write 3 to TIMER (0x3FD).
  - Required: reads 3, 2, 1, 0 on successive cycles. `timer_expired` rises on the edge where TIMER reaches 0. Writing 1 to STATUS clears it one edge later.
- Set/clear collision:
  - Stimulus: write 1 to STATUS[0] on the same edge that TIMER goes from 1 to 0.
  - Required: STATUS[0] remains 1.
- CYCLE and illegal write:
  - Stimulus: read CYCLE on cycles 0 and 5 after reset; then write 0xFF to 0x3FC.
  - Required: reads return 0 and 5. After the write, CYCLE keeps counting and STATUS reads 0x2.
- Reset mid-operation:
  - Stimulus: with GPIO=0xA5 and TIMER=100, pulse `reset` low between edges.
  - Required: `gpio_out`=0, TIMER=0 and STATUS=0 immediately. CYCLE restarts from 0.
